fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage control and F/D pipeline registers for the Y86-64 pipeline. Selects the fetch PC from the predicted PC, a mispredicted-branch fall-through, or a return address. Decodes the fetched icode into the `need_regids` and `need_valC` controls consumed by alignment and PC increment, predicts the next PC and classifies fetch status. Latches the fetched instruction into the D-stage register under stall/bubble control, so it both drives instruction memory and consumes what fetch produces.

## Interface
- `RESET_PC`, default 64'h0: value loaded into F_predPC on reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `f_icode`, `f_ifun` in 4 each: split fields of the fetched byte.
- `f_rA`, `f_rB` in 4 each; `f_valC` in 64; `f_valP` in 64: aligned fields and incremented PC from fetch.
- `imem_error` in 1: fetch address out of range.
- `M_icode` in 4, `M_Cnd` in 1, `M_valA` in 64: memory-stage branch resolution.
- `W_icode` in 4, `W_valM` in 64: writeback-stage return address.
- `F_stall`, `D_stall`, `D_bubble` in 1 each: from pipeline control.
- `f_pc` out 64: address to instruction memory (combinational).
- `need_regids`, `need_valC` out 1 each: to align / pc_increment (combinational).
- `F_predPC` out 64: registered predicted PC.
- `D_stat` out 3; `D_icode`, `D_ifun`, `D_rA`, `D_rB` out 4 each; `D_valC`, `D_valP` out 64 each: D-stage register.

## Operation
- PC select, in priority order:
  - `M_icode==JXX && !M_Cnd` gives `M_valA`.
  - Otherwise `W_icode==RET` gives `W_valM`.
  - Otherwise `F_predPC`.
- Effective icode/ifun: NOP/0 when `imem_error`, else `f_icode`/`f_ifun`.
- `need_regids` = icode in {RRMOVQ/CMOV, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ}.
- `need_valC` = icode in {IRMOVQ, RMMOVQ, MRMOVQ, JXX, CALL}.
- `instr_valid`: icode 0..B. ifun must be 0 except CMOV/JXX (0..6) and OPQ (0..3).
- `f_stat`, in priority order:
  - `imem_error` gives ADR(3).
  - Otherwise `!instr_valid` gives INS(4).
  - Otherwise icode HALT gives HLT(2).
  - Otherwise AOK(1).
- Next prediction: `f_valC` for JXX and CALL, else `f_valP`. Jumps are always predicted taken.
- F register: loads the prediction each cycle unless `F_stall`.
- D register update:
  - `D_stall`: hold. Stall wins over a simultaneous `D_bubble`.
  - `D_bubble`: load the bubble value: stat AOK, icode NOP, ifun 0, rA=rB=F, valC=valP=0.
  - Otherwise load `f_stat`, effective icode/ifun, `f_rA`, `f_rB`, `f_valC`, `f_valP`.
- Register ID fields pass through unchanged. Decode ignores them when the instruction has no register byte.
- Arithmetic: 64-bit, wrap-around. No checks on PC overflow.

## Timing
- `f_pc`, `need_*` and `f_stat` are combinational from inputs and F_predPC in the same cycle.
- One-cycle latency from fetch to D outputs.
- Reset (async assert, sync-safe deassert by system):
  - F_predPC = `RESET_PC`.
  - D register = bubble value.
  - Reset mid-operation discards the in-flight D contents immediately.
- Mispredict and RET redirects take effect in the cycle M/W present them. The wrong-path D contents are squashed by pipeline control via `D_bubble`, not here.
- F_stall with D_bubble: PC held, D bubbled (load/use and ret sequencing rely on this).

## Configuration
- `FETCH_PERF_EN`, when defined, adds three 32-bit outputs, reset to 0 and wrapping on overflow:
  - `perf_fetched`: increments on each cycle D loads a non-bubble instruction.
  - `perf_bubbles`: increments on each cycle D loads a bubble.
  - `perf_mispredicts`: increments on each cycle the M_valA redirect is selected.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants (HALT=0 … POPQ=B).
  - `RNONE`=F.
  - stat constants (AOK=1, HLT=2, ADR=3, INS=4).
  - The D-register bubble constants.
- One sub-module, `d_pipe_reg`: the generic stall/bubble pipeline register parameterised by width and bubble value. It is reused by later stages.

## Test plan
- Reset with `RESET_PC`=0x100, release, no stalls -> `f_pc`=0x100. D outputs read stat 1, icode 1, rA=rB=F, valC=valP=0.
- f_icode=3 (irmovq), f_valP=0x10A -> `need_regids`=1, `need_valC`=1. Next cycle F_predPC=0x10A and D_icode=3.
- f_icode=7, f_valC=0x200 -> next `f_pc`=0x200. Later M_icode=7, M_Cnd=0, M_valA=0x109 -> `f_pc`=0x109 that cycle.
- W_icode=9, W_valM=0x340, F_stall=0 -> `f_pc`=0x340. With M mispredict also present, `f_pc`=M_valA.
- D_stall=1 and D_bubble=1 together -> D unchanged. D_bubble alone -> D_icode=1, D_stat=1. F_stall=1 -> F_predPC unchanged.
- imem_error=1 with f_icode=6 -> D_stat=3, D_icode=1. f_icode=6, f_ifun=5 -> D_stat=4. f_icode=0 -> D_stat=2.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register IDs
// and the D-stage register layout with its bubble value.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;  // also CMOVxx
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    stat:  STAT_AOK,
    icode: NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  64'h0,
    valp:  64'h0
  };

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch stage datapath, pipeline control and
// fetch_ctrl. Optional perf counters appear when FETCH_PERF_EN is defined.
interface fetch_ctrl_if;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        imem_error;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic [63:0] f_pc;
  logic        need_regids;
  logic        need_valC;
  logic [63:0] F_predPC;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_mispredicts;
`endif

  modport slave (
    input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, imem_error,
    input  M_icode, M_Cnd, M_valA, W_icode, W_valM, F_stall, D_stall, D_bubble,
`ifdef FETCH_PERF_EN
    output perf_fetched, perf_bubbles, perf_mispredicts,
`endif
    output f_pc, need_regids, need_valC, F_predPC,
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
  );

  modport master (
    output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, imem_error,
    output M_icode, M_Cnd, M_valA, W_icode, W_valM, F_stall, D_stall, D_bubble,
`ifdef FETCH_PERF_EN
    input  perf_fetched, perf_bubbles, perf_mispredicts,
`endif
    input  f_pc, need_regids, need_valC, F_predPC,
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
  );
endinterface

// File: rtl/d_pipe_reg.sv
// Generic pipeline register with stall (hold) and bubble (load BubbleVal).
// Stall has priority over bubble; reset loads the bubble value.
module d_pipe_reg #(
  parameter int unsigned      Width     = 8,
  parameter logic [Width-1:0] BubbleVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  // Hold on stall, insert bubble, otherwise capture the stage input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= BubbleVal;
    end else if (stall) begin
      q <= q;
    end else if (bubble) begin
      q <= BubbleVal;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Y86-64 fetch-stage control: PC select, icode decode, status, next-PC
// prediction, F register and F/D pipeline register.
// Optional feature macro: FETCH_PERF_EN adds wrapping 32-bit perf counters.
module fetch_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.slave  bus
);

  logic        mispredict;
  logic        ret_sel;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        instr_valid;
  logic [2:0]  f_stat;
  logic [63:0] pred_pc;
  logic [63:0] pred_pc_q;
  d_reg_t      d_in;
  d_reg_t      d_q;

  assign mispredict = (bus.M_icode == JXX) && !bus.M_Cnd;
  assign ret_sel    = (bus.W_icode == RET);

  // Fetch address: mispredict fall-through beats return address beats prediction.
  always_comb begin
    if (mispredict) begin
      bus.f_pc = bus.M_valA;
    end else if (ret_sel) begin
      bus.f_pc = bus.W_valM;
    end else begin
      bus.f_pc = pred_pc_q;
    end
  end

  // A bad fetch address turns the instruction into a NOP so nothing downstream acts on it.
  always_comb begin
    icode = imem_sel_icode(bus.imem_error, bus.f_icode);
    ifun  = bus.imem_error ? 4'h0 : bus.f_ifun;
  end

  assign bus.need_regids = icode inside {RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ};
  assign bus.need_valC   = icode inside {IRMOVQ, RMMOVQ, MRMOVQ, JXX, CALL};

  // Legal icode/ifun combinations.
  always_comb begin
    instr_valid = 1'b0;
    case (icode)
      RRMOVQ, JXX: instr_valid = (ifun <= 4'd6);
      OPQ:         instr_valid = (ifun <= 4'd3);
      HALT, NOP, IRMOVQ, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ:
                   instr_valid = (ifun == 4'h0);
      default:     instr_valid = 1'b0;
    endcase
  end

  // Fetch status classification.
  always_comb begin
    if (bus.imem_error) begin
      f_stat = STAT_ADR;
    end else if (!instr_valid) begin
      f_stat = STAT_INS;
    end else if (icode == HALT) begin
      f_stat = STAT_HLT;
    end else begin
      f_stat = STAT_AOK;
    end
  end

  // Jumps are always predicted taken; calls go to their target.
  assign pred_pc = (icode == JXX || icode == CALL) ? bus.f_valC : bus.f_valP;

  // F register: update the prediction unless fetch is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_pc_q <= RESET_PC;
    end else if (!bus.F_stall) begin
      pred_pc_q <= pred_pc;
    end
  end

  assign bus.F_predPC = pred_pc_q;

  assign d_in = '{
    stat:  f_stat,
    icode: icode,
    ifun:  ifun,
    ra:    bus.f_rA,
    rb:    bus.f_rB,
    valc:  bus.f_valC,
    valp:  bus.f_valP
  };

  d_pipe_reg #(
    .Width     ($bits(d_reg_t)),
    .BubbleVal (D_BUBBLE)
  ) u_d_reg (
    .clk    (clk),
    .rst    (rst),
    .stall  (bus.D_stall),
    .bubble (bus.D_bubble),
    .d      (d_in),
    .q      (d_q)
  );

  assign bus.D_stat  = d_q.stat;
  assign bus.D_icode = d_q.icode;
  assign bus.D_ifun  = d_q.ifun;
  assign bus.D_rA    = d_q.ra;
  assign bus.D_rB    = d_q.rb;
  assign bus.D_valC  = d_q.valc;
  assign bus.D_valP  = d_q.valp;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubbles_q;
  logic [31:0] perf_mispredicts_q;

  // Event counters; they wrap silently on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q     <= 32'd0;
      perf_bubbles_q     <= 32'd0;
      perf_mispredicts_q <= 32'd0;
    end else begin
      if (!bus.D_stall && !bus.D_bubble) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (!bus.D_stall && bus.D_bubble)  perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (mispredict) perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
    end
  end

  assign bus.perf_fetched     = perf_fetched_q;
  assign bus.perf_bubbles     = perf_bubbles_q;
  assign bus.perf_mispredicts = perf_mispredicts_q;
`endif

  function automatic logic [3:0] imem_sel_icode(input logic err, input logic [3:0] raw);
    return err ? NOP : raw;
  endfunction

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with RESET_PC = 0x100.
module tb_fetch_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (64'h100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [63:0] icode, ifun, valc, valp, imem;
    bit [63:0] m_icode, m_cnd, m_vala, w_icode, w_valm;
    bit [63:0] f_stall, d_stall, d_bubble;
    bit [63:0] e_fpc, e_nr, e_nc, e_pred, e_stat, e_icode, e_ifun;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic idle_inputs();
    bus.f_icode    = 4'h1;
    bus.f_ifun     = 4'h0;
    bus.f_rA       = 4'hF;
    bus.f_rB       = 4'hF;
    bus.f_valC     = 64'h0;
    bus.f_valP     = 64'h0;
    bus.imem_error = 1'b0;
    bus.M_icode    = 4'h1;
    bus.M_Cnd      = 1'b1;
    bus.M_valA     = 64'h0;
    bus.W_icode    = 4'h1;
    bus.W_valM     = 64'h0;
    bus.F_stall    = 1'b0;
    bus.D_stall    = 1'b0;
    bus.D_bubble   = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    // icode ifun valC valP imem | Mi Mc MvalA Wi WvalM | Fs Ds Db | fpc nr nc pred stat icode ifun
    vecs[0]  = '{3, 0, 'h55, 'h10A, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h100, 1, 1, 'h10A, 1, 3, 0};
    vecs[1]  = '{7, 0, 'h200, 'h113, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h10A, 0, 1, 'h200, 1, 7, 0};
    vecs[2]  = '{6, 1, 0, 'h202, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h200, 1, 0, 'h202, 1, 6, 1};
    vecs[3]  = '{1, 0, 0, 'h10A, 0, 7, 0, 'h109, 1, 0, 0, 0, 0, 'h109, 0, 0, 'h10A, 1, 1, 0};
    vecs[4]  = '{0, 0, 0, 'h341, 0, 1, 1, 0, 9, 'h340, 0, 0, 0, 'h340, 0, 0, 'h341, 2, 0, 0};
    vecs[5]  = '{'hA, 0, 0, 'h10B, 0, 7, 0, 'h109, 9, 'h340, 0, 0, 0, 'h109, 1, 0, 'h10B, 1, 'hA, 0};
    vecs[6]  = '{2, 3, 0, 'h10D, 0, 1, 1, 0, 1, 0, 0, 1, 1, 'h10B, 1, 0, 'h10D, 1, 'hA, 0};
    vecs[7]  = '{8, 0, 'h400, 'h116, 0, 1, 1, 0, 1, 0, 1, 0, 1, 'h10D, 0, 1, 'h10D, 1, 1, 0};
    vecs[8]  = '{6, 0, 0, 'h10F, 1, 1, 1, 0, 1, 0, 0, 0, 0, 'h10D, 0, 0, 'h10F, 3, 1, 0};
    vecs[9]  = '{6, 5, 0, 'h111, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h10F, 1, 0, 'h111, 4, 6, 5};
    vecs[10] = '{'hC, 0, 0, 'h112, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h111, 0, 0, 'h112, 4, 'hC, 0};
    vecs[11] = '{2, 6, 0, 'h114, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h112, 1, 0, 'h114, 1, 2, 6};
    vecs[12] = '{8, 0, 'h500, 'h11D, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h114, 0, 1, 'h500, 1, 8, 0};
    vecs[13] = '{6, 4, 0, 'h502, 0, 1, 1, 0, 1, 0, 0, 0, 0, 'h500, 1, 0, 'h502, 4, 6, 4};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_f_pc", bus.f_pc, 64'h100);
    chk("reset_predpc", bus.F_predPC, 64'h100);
    chk("reset_d_stat", 64'(bus.D_stat), 64'd1);
    chk("reset_d_icode", 64'(bus.D_icode), 64'd1);
    chk("reset_d_ra", 64'(bus.D_rA), 64'hF);
    chk("reset_d_rb", 64'(bus.D_rB), 64'hF);
    chk("reset_d_valc", bus.D_valC, 64'h0);
    chk("reset_d_valp", bus.D_valP, 64'h0);

    for (int i = 0; i < 14; i++) begin
      bus.f_icode    = vecs[i].icode[3:0];
      bus.f_ifun     = vecs[i].ifun[3:0];
      bus.f_rA       = 4'h1;
      bus.f_rB       = 4'h2;
      bus.f_valC     = vecs[i].valc;
      bus.f_valP     = vecs[i].valp;
      bus.imem_error = vecs[i].imem[0];
      bus.M_icode    = vecs[i].m_icode[3:0];
      bus.M_Cnd      = vecs[i].m_cnd[0];
      bus.M_valA     = vecs[i].m_vala;
      bus.W_icode    = vecs[i].w_icode[3:0];
      bus.W_valM     = vecs[i].w_valm;
      bus.F_stall    = vecs[i].f_stall[0];
      bus.D_stall    = vecs[i].d_stall[0];
      bus.D_bubble   = vecs[i].d_bubble[0];
      #1;
      chk($sformatf("v%0d_f_pc", i), bus.f_pc, vecs[i].e_fpc);
      chk($sformatf("v%0d_need_regids", i), 64'(bus.need_regids), vecs[i].e_nr);
      chk($sformatf("v%0d_need_valC", i), 64'(bus.need_valC), vecs[i].e_nc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_predpc", i), bus.F_predPC, vecs[i].e_pred);
      chk($sformatf("v%0d_d_stat", i), 64'(bus.D_stat), vecs[i].e_stat);
      chk($sformatf("v%0d_d_icode", i), 64'(bus.D_icode), vecs[i].e_icode);
      chk($sformatf("v%0d_d_ifun", i), 64'(bus.D_ifun), vecs[i].e_ifun);
    end

    // Register fields and constants pass through to D.
    idle_inputs();
    bus.f_icode = 4'h3;
    bus.f_rA    = 4'hF;
    bus.f_rB    = 4'h5;
    bus.f_valC  = 64'h1234;
    bus.f_valP  = 64'h600;
    @(posedge clk);
    #1;
    chk("load_d_ra", 64'(bus.D_rA), 64'hF);
    chk("load_d_rb", 64'(bus.D_rB), 64'h5);
    chk("load_d_valc", bus.D_valC, 64'h1234);
    chk("load_d_valp", bus.D_valP, 64'h600);

    // Bubble clears every D field to the bubble value.
    bus.D_bubble = 1'b1;
    @(posedge clk);
    #1;
    chk("bubble_d_ra", 64'(bus.D_rA), 64'hF);
    chk("bubble_d_rb", 64'(bus.D_rB), 64'hF);
    chk("bubble_d_valc", bus.D_valC, 64'h0);
    chk("bubble_d_valp", bus.D_valP, 64'h0);
    chk("bubble_d_icode", 64'(bus.D_icode), 64'h1);

    // Asynchronous reset in mid-cycle discards live D contents at once.
    bus.D_bubble = 1'b0;
    bus.f_icode  = 4'h5;
    bus.f_valP   = 64'h700;
    @(posedge clk);
    #1;
    chk("pre_rst_d_icode", 64'(bus.D_icode), 64'h5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_d_icode", 64'(bus.D_icode), 64'h1);
    chk("async_rst_d_valp", bus.D_valP, 64'h0);
    chk("async_rst_predpc", bus.F_predPC, 64'h100);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
